// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold/load/shift/rotate per edge, plus a counted
// burst engine that repeats one shift/rotate op for cnt enabled edges.
module univ_shift_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic             sin_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sout_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       mode_lat_q, mode_lat_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       mode_eff_c;

  // One register operation; hold and the unused 11x codes leave q unchanged.
  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       m,
                                                input logic [WIDTH-1:0] cur,
                                                input logic             s,
                                                input logic [WIDTH-1:0] ld);
    logic [WIDTH-1:0] r;
    r = cur;
    case (m)
      M_LOAD:  r = ld;
      M_SHL:   r = {cur[WIDTH-2:0], s};
      M_SHR:   r = {s, cur[WIDTH-1:1]};
      M_ROL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROR:   r = {cur[0], cur[WIDTH-1:1]};
      default: r = cur;
    endcase
    return r;
  endfunction

  // Only shift/rotate codes can be bursted.
  function automatic logic is_shift(input logic [2:0] m);
    return (m >= M_SHL) && (m <= M_ROR);
  endfunction

  // State register; done is a pulse so it clears on every edge regardless of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      q_q        <= RESET_VAL;
      rem_q      <= '0;
      mode_lat_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      rem_q      <= rem_d;
      mode_lat_q <= mode_lat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state: plain register in IDLE, latched-mode burst in RUN.
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    rem_d      = rem_q;
    mode_lat_d = mode_lat_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (en_i) begin
      case (state_q)
        S_IDLE: begin
          if (start_i && is_shift(mode_i)) begin
            if (cnt_i == '0) begin
              done_d = 1'b1;
            end else begin
              q_d = apply_op(mode_i, q_q, sin_i, d_i);
              if (cnt_i == CNT_W'(1)) begin
                done_d = 1'b1;
              end else begin
                state_d    = S_RUN;
                mode_lat_d = mode_i;
                rem_d      = cnt_i - CNT_W'(1);
                busy_d     = 1'b1;
              end
            end
          end else begin
            q_d = apply_op(mode_i, q_q, sin_i, d_i);
          end
        end
        S_RUN: begin
          q_d   = apply_op(mode_lat_q, q_q, sin_i, d_i);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Serial out follows the op direction: latched mode during a burst, live mode otherwise.
  always_comb begin
    mode_eff_c = (state_q == S_RUN) ? mode_lat_q : mode_i;
    sout_o     = ((mode_eff_c == M_SHL) || (mode_eff_c == M_ROL)) ? q_q[WIDTH-1] : q_q[0];
  end

  assign q_o    = q_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: a behavioural model predicts q/busy/done/sout
// at drive time, the prediction is queued and popped after the clock edge.
module tb_univ_shift_reg;

  localparam logic [7:0] RV = 8'h5A;
  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3, ROL = 3'd4, ROR = 3'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_i, sin_i, start_i;
  logic [2:0] mode_i;
  logic [7:0] d_i;
  logic [3:0] cnt_i;
  logic [7:0] q_o;
  logic       sout_o, busy_o, done_o;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i), .sin_i(sin_i), .d_i(d_i),
    .start_i(start_i), .cnt_i(cnt_i), .q_o(q_o), .sout_o(sout_o), .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       sout;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state
  logic [7:0] m_q;
  logic       m_busy, m_done, m_run;
  logic [3:0] m_rem;
  logic [2:0] m_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] op_m(input logic [2:0] m, input logic [7:0] c,
                                      input logic s, input logic [7:0] ld);
    case (m)
      LOAD:    return ld;
      SHL:     return {c[6:0], s};
      SHR:     return {s, c[7:1]};
      ROL:     return {c[6:0], c[7]};
      ROR:     return {c[0], c[7:1]};
      default: return c;
    endcase
  endfunction

  task automatic model_reset();
    m_q = RV; m_busy = 1'b0; m_done = 1'b0; m_run = 1'b0; m_rem = '0; m_mode = HOLD;
  endtask

  // Drive one cycle, predict, push; after the edge pop and compare.
  task automatic step(input logic en, input logic [2:0] mode, input logic sin,
                      input logic [7:0] d, input logic start, input logic [3:0] cnt,
                      input string tag);
    exp_t e;
    logic nd;
    logic [2:0] em;
    en_i = en; mode_i = mode; sin_i = sin; d_i = d; start_i = start; cnt_i = cnt;
    nd = 1'b0;
    if (en) begin
      if (m_run) begin
        m_q = op_m(m_mode, m_q, sin, d);
        if (m_rem == 4'd1) begin
          m_run = 1'b0; m_busy = 1'b0; nd = 1'b1;
        end
        m_rem = m_rem - 4'd1;
      end else if (start && mode >= SHL && mode <= ROR) begin
        if (cnt == 4'd0) nd = 1'b1;
        else begin
          m_q = op_m(mode, m_q, sin, d);
          if (cnt == 4'd1) nd = 1'b1;
          else begin
            m_run = 1'b1; m_busy = 1'b1; m_rem = cnt - 4'd1; m_mode = mode;
          end
        end
      end else begin
        m_q = op_m(mode, m_q, sin, d);
      end
    end
    m_done = nd;
    em = m_run ? m_mode : mode;
    e.q = m_q; e.busy = m_busy; e.done = m_done;
    e.sout = (em == SHL || em == ROL) ? m_q[7] : m_q[0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".q"},    32'(q_o),    32'(e.q));
    chk({tag, ".busy"}, 32'(busy_o), 32'(e.busy));
    chk({tag, ".done"}, 32'(done_o), 32'(e.done));
    chk({tag, ".sout"}, 32'(sout_o), 32'(e.sout));
  endtask

  initial begin
    rst = 1'b1; en_i = 1'b0; mode_i = HOLD; sin_i = 1'b0; d_i = '0; start_i = 1'b0; cnt_i = '0;
    model_reset();
    #3;
    chk("rst.q", 32'(q_o), 32'(RV));
    chk("rst.busy", 32'(busy_o), 0);
    chk("rst.done", 32'(done_o), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // load then single shifts
    step(1, LOAD, 0, 8'hA5, 0, 0, "t2_ld");
    step(1, SHL,  1, 8'h00, 0, 0, "t2_shl");
    chk("t2_shl_val", 32'(q_o), 32'h4B);
    step(1, LOAD, 0, 8'hA5, 0, 0, "t2_ld2");
    step(1, SHR,  1, 8'h00, 0, 0, "t2_shr");
    chk("t2_shr_val", 32'(q_o), 32'hD2);

    // ROL burst of 3, then a back-to-back ROR burst started on the done cycle
    step(1, LOAD, 0, 8'h81, 0, 0, "t3_ld");
    step(1, ROL,  0, 8'h00, 1, 3, "t3_s1");
    chk("t3_q1", 32'(q_o), 32'h03); chk("t3_busy1", 32'(busy_o), 1);
    step(1, LOAD, 0, 8'hFF, 1, 9, "t3_s2");
    chk("t3_q2", 32'(q_o), 32'h06); chk("t3_busy2", 32'(busy_o), 1);
    step(1, HOLD, 0, 8'h00, 0, 0, "t3_s3");
    chk("t3_q3", 32'(q_o), 32'h0C); chk("t3_busy3", 32'(busy_o), 0); chk("t3_done3", 32'(done_o), 1);
    step(1, ROR,  0, 8'h00, 1, 2, "t3_b2a");
    chk("t3_b2a_q", 32'(q_o), 32'h06); chk("t3_b2a_done", 32'(done_o), 0);
    step(1, HOLD, 0, 8'h00, 0, 0, "t3_b2b");
    chk("t3_b2b_q", 32'(q_o), 32'h03); chk("t3_b2b_done", 32'(done_o), 1);

    // same burst with en low for two cycles after the first shift
    step(1, LOAD, 0, 8'h81, 0, 0, "t4_ld");
    step(1, ROL,  0, 8'h00, 1, 3, "t4_s1");
    step(0, HOLD, 0, 8'h00, 0, 0, "t4_h1");
    step(0, SHR,  1, 8'h00, 0, 0, "t4_h2");
    chk("t4_hold_q", 32'(q_o), 32'h03); chk("t4_hold_busy", 32'(busy_o), 1);
    step(1, HOLD, 0, 8'h00, 0, 0, "t4_s2");
    step(1, HOLD, 0, 8'h00, 0, 0, "t4_s3");
    chk("t4_q3", 32'(q_o), 32'h0C); chk("t4_done3", 32'(done_o), 1);

    // cnt=0 burst and start with a non-shift mode
    step(1, LOAD, 0, 8'h33, 0, 0, "t5_ld");
    step(1, SHL,  1, 8'h00, 1, 0, "t5_c0");
    chk("t5_c0_q", 32'(q_o), 32'h33); chk("t5_c0_done", 32'(done_o), 1);
    step(1, LOAD, 0, 8'h77, 1, 3, "t5_ldst");
    chk("t5_ldst_q", 32'(q_o), 32'h77); chk("t5_ldst_done", 32'(done_o), 0);
    step(1, SHR,  0, 8'h00, 1, 1, "t5_c1");
    chk("t5_c1_q", 32'(q_o), 32'h3B); chk("t5_c1_done", 32'(done_o), 1);

    // en=0 freezes q; sout follows live mode
    step(0, LOAD, 0, 8'hFF, 0, 0, "t6_frz");
    chk("t6_frz_q", 32'(q_o), 32'h3B);
    step(0, SHL, 0, 8'h00, 0, 0, "t6_shl");
    chk("t6_sout_shl", 32'(sout_o), 0);
    step(0, SHR, 0, 8'h00, 0, 0, "t6_shr");
    chk("t6_sout_shr", 32'(sout_o), 1);

    // reset mid-burst after two shifts
    step(1, LOAD, 0, 8'h96, 0, 0, "t1_ld");
    step(1, SHL,  0, 8'h00, 1, 5, "t1_s1");
    step(1, HOLD, 0, 8'h00, 0, 0, "t1_s2");
    chk("t1_pre_q", 32'(q_o), 32'h58);
    rst = 1'b1;
    #2;
    chk("t1_rst_q", 32'(q_o), 32'(RV));
    chk("t1_rst_busy", 32'(busy_o), 0);
    chk("t1_rst_done", 32'(done_o), 0);
    rst = 1'b0;
    model_reset();
    step(1, HOLD, 0, 8'h00, 0, 0, "t1_post");
    step(1, HOLD, 0, 8'h00, 0, 0, "t1_post2");

    // random mix
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           8'($urandom), 1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 5)), "rnd");
    end

    chk("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
